// File: rtl/instruction_fetch.sv
// Instruction fetch: PC register, instruction-memory request, and a small prefetch FIFO toward decode.
// Optional out-of-range fetch detection is enabled by defining FETCH_BOUNDS_CHECK_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned ADDR_WORD_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W = 65;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instruction_fetch: FIFO_DEPTH must be a power of two >= 2");
  end
  if (ADDR_WORD_BITS < 1 || ADDR_WORD_BITS > 30) begin : g_bad_addr_bits
    $error("instruction_fetch: ADDR_WORD_BITS must be in 1..30");
  end

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;
  logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];

  logic             pop, push;
  logic [31:0]      push_instr;
  logic             push_fault;
  logic [ENTRY_W-1:0] head;

  assign imem_addr = {2'b00, pc_q[31:2]};

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [31:0] WORD_LIMIT = 32'(1) << ADDR_WORD_BITS;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  logic out_of_range;

  // Fetches beyond the implemented memory become a faulting NOP and stall the stream.
  assign out_of_range = (32'(pc_q[31:2]) >= WORD_LIMIT);
  assign push_instr   = out_of_range ? NOP_INSTR : imem_instr;
  assign push_fault   = out_of_range;
`else
  assign push_instr   = imem_instr;
  assign push_fault   = 1'b0;
`endif

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = !redirect_valid && !halted_q &&
                     ((count_q < CNT_W'(FIFO_DEPTH)) || pop);

  assign head      = fifo_q[rd_q];
  assign out_pc    = out_valid ? head[64:33] : 32'h0;
  assign out_instr = out_valid ? head[32:1]  : 32'h0;
  assign out_fault = out_valid & head[0];

  // Next-state: redirect flushes and restarts; otherwise independent push/pop.
  always_comb begin
    pc_d     = pc_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      rd_d     = '0;
      wr_d     = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_d     = wr_q + PTR_W'(1);
        halted_d = push_fault;
      end
      if (pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC & 32'hFFFF_FFFC;
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Storage needs no reset; empty entries are masked at the outputs.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_q[wr_q] <= {pc_q, push_instr, push_fault};
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, backpressure, redirect, mid-stream reset,
// and either PC wrap (default build) or out-of-range fault (FETCH_BOUNDS_CHECK_EN).
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  int n_assert = 0;
  int n_fail   = 0;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  // Memory model: low half of each word is its word index.
  assign imem_instr = {16'hC0DE, imem_addr[15:0]};

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return {16'hC0DE, pc[17:2]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    out_pc,         32'h0);
    chk("rst_instr", out_instr,      32'h0);
    chk("rst_fault", 32'(out_fault), 32'd0);
    chk("rst_addr",  imem_addr,      32'h0);

    // Streaming with out_ready high: one instruction per cycle.
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc",    out_pc,         32'(k * 4));
      chk("stream_instr", out_instr,      exp_instr(32'(k * 4)));
    end

    // Backpressure: head 12 held, FIFO fills with 16, fetch freezes at pc 20.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_pc",    out_pc,         32'd12);
      chk("hold_instr", out_instr,      exp_instr(32'd12));
    end
    chk("hold_addr", imem_addr, 32'd5);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("resume_pc", out_pc, 32'(16 + k * 4));
    end

    // Redirect while full with out_ready high.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid0", 32'(out_valid), 32'd0);
    chk("redir_pc0",    out_pc,         32'h0);
    chk("redir_addr",   imem_addr,      32'h40);
    step();
    chk("redir_valid1", 32'(out_valid), 32'd1);
    chk("redir_pc1",    out_pc,         32'h100);
    chk("redir_instr1", out_instr,      32'hC0DE_0040);
    step();
    chk("redir_pc2",    out_pc,         32'h104);

    // One-cycle reset mid-stream.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    step();
    chk("mrst_pc",    out_pc,         32'h0);
    chk("mrst_v1",    32'(out_valid), 32'd1);
    step();
    chk("mrst_pc4",   out_pc,         32'h4);

`ifndef FETCH_BOUNDS_CHECK_EN
    // PC wraps from the top of the address space to zero.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_valid0", 32'(out_valid), 32'd0);
    step();
    chk("wrap_pc_top", out_pc,         32'hFFFF_FFFC);
    chk("wrap_instr",  out_instr,      32'hC0DE_FFFF);
    chk("wrap_fault",  32'(out_fault), 32'd0);
    step();
    chk("wrap_pc0",    out_pc,         32'h0);
    chk("wrap_instr0", out_instr,      32'hC0DE_0000);
`else
    // Out-of-range fetch yields one faulting NOP, then the stream halts.
    redirect_valid = 1'b1; redirect_pc = 32'h0004_0000;
    step();
    redirect_valid = 1'b0;
    step();
    chk("flt_valid", 32'(out_valid), 32'd1);
    chk("flt_fault", 32'(out_fault), 32'd1);
    chk("flt_instr", out_instr,      32'h0000_0013);
    chk("flt_pc",    out_pc,         32'h0004_0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("halt_valid", 32'(out_valid), 32'd0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    chk("resume_valid", 32'(out_valid), 32'd1);
    chk("resume_pc0",   out_pc,         32'h0);
    chk("resume_fault", 32'(out_fault), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
